// File: rtl/npu_pkg.sv
// Shared constants, FSM encoding and read-mask helper for the line-buffer controller.
package npu_pkg;

    localparam int unsigned IMG_W_DFLT = 6;
    localparam int unsigned NUM_LB     = 4;
    localparam int unsigned WIDTH_DFLT = 8;
    localparam int unsigned SEL_W      = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } lb_state_e;

    // Three consecutive buffers starting at the top row; the fourth is the write target.
    function automatic logic [NUM_LB-1:0] rd_mask(input logic [SEL_W-1:0] top);
        logic [NUM_LB-1:0] m;
        m = '1;
        m[top + SEL_W'(3)] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with enable and a combinational wrap pulse.
module mod_counter #(
    parameter int unsigned MOD = 4,
    localparam int unsigned CNT_W = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign o_wrap_c = i_en && (count_q == CNT_W'(MOD - 1));
    assign o_count  = count_q;

    // Next count: hold, increment, or wrap to zero at MOD-1.
    always_comb begin
        count_d = count_q;
        if (i_en) begin
            count_d = o_wrap_c ? '0 : count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/linebuf_ctrl.sv
// Write/read sequencing for four rotating line buffers feeding a 3x3 window.
module linebuf_ctrl
    import npu_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DFLT,
    parameter int unsigned WIDTH = WIDTH_DFLT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pix_valid,
    input  logic [WIDTH-1:0]  i_pix_data,
    output logic              o_pix_ready,
    output logic [NUM_LB-1:0] o_lb_wr_en,
    output logic [WIDTH-1:0]  o_lb_wdata,
    output logic [NUM_LB-1:0] o_lb_rd_en,
    output logic [SEL_W-1:0]  o_top_sel,
    output logic              o_win_valid,
    output logic              o_row_done
);

    localparam int unsigned COL_W     = $clog2(IMG_W);
    localparam int unsigned CAP       = NUM_LB * IMG_W;
    localparam int unsigned FILL_W    = $clog2(CAP + 1);
    localparam int unsigned START_LVL = 3 * IMG_W;

    lb_state_e         state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [NUM_LB-1:0] rd_en_q, rd_en_d;
    logic              win_valid_q, win_valid_d;
    logic              row_done_q, row_done_d;
    logic [COL_W-1:0]  rd_col_d;

    logic              accept;
    logic              rd_active;
    logic              last_rd;
    logic [COL_W-1:0]  wr_col;
    logic [COL_W-1:0]  rd_col;
    logic [SEL_W-1:0]  wr_sel;
    logic [SEL_W-1:0]  rd_sel;
    logic              wr_col_wrap;
    logic              wr_sel_wrap;
    logic              rd_sel_wrap;
    logic              unused_wraps;

    // No pixel is taken while reset is held, so the write strobes stay quiet.
    assign o_pix_ready  = (fill_q < FILL_W'(CAP));
    assign accept       = i_pix_valid & o_pix_ready & ~i_rst;
    assign rd_active    = (state_q == ST_READ);
    assign unused_wraps = wr_sel_wrap ^ rd_sel_wrap;

    mod_counter #(.MOD(IMG_W)) u_wr_col (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(accept),
        .o_count(wr_col), .o_wrap_c(wr_col_wrap)
    );

    mod_counter #(.MOD(NUM_LB)) u_wr_sel (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(wr_col_wrap),
        .o_count(wr_sel), .o_wrap_c(wr_sel_wrap)
    );

    mod_counter #(.MOD(IMG_W)) u_rd_col (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(rd_active),
        .o_count(rd_col), .o_wrap_c(last_rd)
    );

    mod_counter #(.MOD(NUM_LB)) u_rd_sel (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(last_rd),
        .o_count(rd_sel), .o_wrap_c(rd_sel_wrap)
    );

    // Write strobe follows the accepted pixel into the current write buffer.
    always_comb begin
        o_lb_wr_en = '0;
        if (accept) begin
            o_lb_wr_en[wr_sel] = 1'b1;
        end
    end

    assign o_lb_wdata = i_pix_data;
    assign o_top_sel  = rd_sel;
    assign o_lb_rd_en = rd_en_q;
    assign o_win_valid = win_valid_q;
    assign o_row_done  = row_done_q;

    // Next state, occupancy and the registered read-side outputs.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        rd_col_d    = rd_col;
        rd_en_d     = '0;
        win_valid_d = 1'b0;
        row_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fill_q >= FILL_W'(START_LVL)) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                rd_col_d = last_rd ? '0 : rd_col + COL_W'(1);
                if (last_rd) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case ({accept, last_rd})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(IMG_W);
            2'b11:   fill_d = fill_q + FILL_W'(1) - FILL_W'(IMG_W);
            default: fill_d = fill_q;
        endcase

        // rd_sel only moves on the cycle that leaves READ, so it is stable here.
        if (state_d == ST_READ) begin
            rd_en_d     = rd_mask(rd_sel);
            win_valid_d = (rd_col_d <= COL_W'(IMG_W - 3));
            row_done_d  = (rd_col_d == COL_W'(IMG_W - 1));
        end
    end

    // FSM state, occupancy and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            fill_q      <= '0;
            rd_en_q     <= '0;
            win_valid_q <= 1'b0;
            row_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            rd_en_q     <= rd_en_d;
            win_valid_q <= win_valid_d;
            row_done_q  <= row_done_d;
        end
    end

endmodule

// File: doc/linebuf_ctrl.md
LINEBUF_CTRL -- requirements
Module: linebuf_ctrl

Interface
REQ-001 Parameter IMG_W, default 6, pixels per image row; legal range 3..64.
REQ-002 Parameter NUM_LB, fixed 4, number of line buffers under control.
REQ-003 Parameter WIDTH, default 8, pixel width in bits.
REQ-004 i_clk  in  1  clock; all state changes on the rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_pix_valid  in  1  upstream pixel present.
REQ-007 i_pix_data  in  WIDTH  upstream pixel.
REQ-008 o_pix_ready  out  1  controller accepts a pixel this cycle.
REQ-009 o_lb_wr_en  out  NUM_LB  per-buffer write strobe.
REQ-010 o_lb_wdata  out  WIDTH  write data broadcast to all buffers.
REQ-011 o_lb_rd_en  out  NUM_LB  per-buffer read-advance strobe.
REQ-012 o_top_sel  out  2  index of the buffer holding the oldest (top) window row.
REQ-013 o_win_valid  out  1  3x3 window on the buffer outputs is valid this cycle.
REQ-014 o_row_done  out  1  one-cycle pulse: one output row of windows completed.

Function
REQ-015 Accept = i_pix_valid & o_pix_ready; o_pix_ready = (fill_cnt < NUM_LB*IMG_W), decoded from registers only.
REQ-016 o_lb_wr_en is one-hot at bit wr_sel when accept=1, all-zero otherwise (combinational); o_lb_wdata = i_pix_data.
REQ-017 wr_col counts accepted pixels 0..IMG_W-1; on accept at IMG_W-1 it wraps to 0 and wr_sel increments mod 4.
REQ-018 fill_cnt (0..NUM_LB*IMG_W) tracks buffered unread pixels: +1 per accept, -IMG_W on the last READ cycle, +1-IMG_W when both occur in the same cycle.
REQ-019 FSM states IDLE, READ; IDLE->READ when registered fill_cnt >= 3*IMG_W; READ->IDLE after exactly IMG_W READ cycles; IDLE always lasts at least one cycle.
REQ-020 In READ, o_lb_rd_en (registered) has bits rd_sel, rd_sel+1, rd_sel+2 (mod 4) set; bit rd_sel+3 is zero.
REQ-021 rd_col counts READ cycles 0..IMG_W-1; o_win_valid = 1 for rd_col 0..IMG_W-3, 0 for the final two cycles.
REQ-022 On the READ cycle with rd_col = IMG_W-1: o_row_done pulses, rd_sel increments mod 4, rd_col returns to 0.
REQ-023 o_top_sel = rd_sel at all times.
REQ-024 Writes continue during READ into the non-read buffer; wr_sel never equals a buffer being read (guaranteed by REQ-015 bound).
REQ-025 Backpressure: at fill_cnt = NUM_LB*IMG_W, o_pix_ready = 0 until the decrement in REQ-018 takes effect; no pixel is dropped or overwritten.

Reset
REQ-026 On i_rst: state IDLE; wr_sel, wr_col, rd_sel, rd_col, fill_cnt = 0.
REQ-027 Reset outputs: o_pix_ready = 1, o_lb_wr_en = 0, o_lb_rd_en = 0, o_top_sel = 0, o_win_valid = 0, o_row_done = 0.
REQ-028 Reset asserted mid-READ aborts the row immediately; no o_row_done pulse is produced.

Structure
REQ-029 Shared package npu_pkg holds IMG_W default, NUM_LB, WIDTH and the FSM state encoding.
REQ-030 One sub-module mod_counter (parameterised modulus, enable, wrap pulse) is instantiated for wr_col, wr_sel, rd_col and rd_sel.

Verification (IMG_W=6)
REQ-031 Stream 18 pixels back-to-back from reset -> first o_lb_rd_en = 4'b0111 one cycle after the cycle fill_cnt becomes 18; READ lasts 6 cycles; o_win_valid high 4 cycles; o_row_done once; o_top_sel then 1.
REQ-032 Stream continuously with no reads possible -> after 24 buffered pixels o_pix_ready = 0; released after the first row's final READ cycle.
REQ-033 Accept on the final READ cycle -> fill_cnt changes by -5, not -6 or +1.
REQ-034 Stream 42 pixels -> five row_done pulses total; o_lb_rd_en sequence 0111, 1110, 1101, 1011, 0111 (rd_sel wraps 3->0).
REQ-035 Assert i_rst at READ cycle 3 -> all outputs at reset values next cycle; no o_row_done; restarting from 18 new pixels reproduces REQ-031.
